lcd_bus_arbiter: RTL and testbench



---
 rtl/lcd_bus_arbiter_if.sv | 34 +++
 rtl/lcd_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : lcd_bus_arbiter_if
// Brief   : Requester command fields and shared nibble-writer command port.
// Rev     : 1.0  initial release
// ============================================================================
interface lcd_bus_arbiter_if;
    logic       i_req0, i_req1;
    logic       i_lock0, i_lock1;
    logic       i_long0, i_long1;
    logic       i_data0, i_data1;
    logic [2:0] i_sel0, i_sel1;
    logic [3:0] i_val0, i_val1;
    logic       o_ack0, o_ack1;
    logic       o_data;
    logic [2:0] o_sel;
    logic [3:0] o_val;
    logic       o_e_trigger;
    logic       o_busy;
    logic       o_owner;

    // master: the requester side; slave: the arbiter serving them
    modport master (
        output i_req0, i_req1, i_lock0, i_lock1, i_long0, i_long1,
               i_data0, i_data1, i_sel0, i_sel1, i_val0, i_val1,
        input  o_ack0, o_ack1, o_data, o_sel, o_val, o_e_trigger, o_busy, o_owner
    );
    modport slave (
        input  i_req0, i_req1, i_lock0, i_lock1, i_long0, i_long1,
               i_data0, i_data1, i_sel0, i_sel1, i_val0, i_val1,
        output o_ack0, o_ack1, o_data, o_sel, o_val, o_e_trigger, o_busy, o_owner
    );
endinterface
`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : lcd_bus_arbiter
// Brief   : Two-requester HD44780 command arbiter with busy wait and burst lock.
//           Define LCD_ARB_RR_EN for round-robin; fixed priority otherwise.
// Rev     : 1.0  initial release
// ============================================================================
module lcd_bus_arbiter #(
    parameter int WAIT_SHORT = 35,
    parameter int WAIT_LONG  = 1320
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_ena,
    lcd_bus_arbiter_if.slave bus
);
    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_SETUP  = 2'd1;
    localparam logic [1:0]  c_ST_ISSUE  = 2'd2;
    localparam logic [1:0]  c_ST_WAIT   = 2'd3;
    localparam logic [11:0] c_CNT_SHORT = 12'(WAIT_SHORT);
    localparam logic [11:0] c_CNT_LONG  = 12'(WAIT_LONG);

    logic [1:0]  r_state, w_state_nxt;
    logic        r_ack0, r_ack1, r_data, r_trig, r_busy, r_owner, r_long, r_lock;
    logic [2:0]  r_sel;
    logic [3:0]  r_val;
    logic [11:0] r_cnt;
    logic        w_ack0_nxt, w_ack1_nxt, w_data_nxt, w_trig_nxt, w_busy_nxt;
    logic        w_owner_nxt, w_long_nxt, w_lock_nxt;
    logic [2:0]  w_sel_nxt;
    logic [3:0]  w_val_nxt;
    logic [11:0] w_cnt_nxt;
    logic        w_elig0, w_elig1, w_grant, w_pick1;

    // While locked only the current owner may compete
    assign w_elig0 = bus.i_req0 && (!r_lock || !r_owner);
    assign w_elig1 = bus.i_req1 && (!r_lock ||  r_owner);
    assign w_grant = w_elig0 || w_elig1;

`ifdef LCD_ARB_RR_EN
    logic r_rr_ptr;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            r_rr_ptr <= 1'b1;
        else if (r_state == c_ST_IDLE && w_grant)
            r_rr_ptr <= w_pick1;
    end

    assign w_pick1 = w_elig1 && (!w_elig0 || !r_rr_ptr);
`else
    assign w_pick1 = w_elig1 && !w_elig0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_grant) w_state_nxt = c_ST_SETUP;
            c_ST_SETUP: w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: if (i_ena) w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if (i_ena && r_cnt <= 12'd1) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        w_data_nxt  = r_data;
        w_sel_nxt   = r_sel;
        w_val_nxt   = r_val;
        w_long_nxt  = r_long;
        w_lock_nxt  = r_lock;
        w_owner_nxt = r_owner;
        w_busy_nxt  = r_busy;
        w_trig_nxt  = r_trig;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant) begin
                    w_ack0_nxt  = !w_pick1;
                    w_ack1_nxt  = w_pick1;
                    w_owner_nxt = w_pick1;
                    w_busy_nxt  = 1'b1;
                    w_data_nxt  = w_pick1 ? bus.i_data1 : bus.i_data0;
                    w_sel_nxt   = w_pick1 ? bus.i_sel1  : bus.i_sel0;
                    w_val_nxt   = w_pick1 ? bus.i_val1  : bus.i_val0;
                    w_long_nxt  = w_pick1 ? bus.i_long1 : bus.i_long0;
                    w_lock_nxt  = w_pick1 ? bus.i_lock1 : bus.i_lock0;
                end
            end
            c_ST_SETUP: w_trig_nxt = 1'b1;
            c_ST_ISSUE: begin
                if (i_ena) begin
                    w_trig_nxt = 1'b0;
                    w_cnt_nxt  = r_long ? c_CNT_LONG : c_CNT_SHORT;
                end
            end
            c_ST_WAIT: begin
                if (i_ena) begin
                    if (r_cnt <= 12'd1) begin
                        w_cnt_nxt  = 12'd0;
                        w_busy_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt  = r_cnt - 12'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_data  <= 1'b0;
            r_sel   <= 3'd0;
            r_val   <= 4'd0;
            r_long  <= 1'b0;
            r_lock  <= 1'b0;
            r_owner <= 1'b0;
            r_busy  <= 1'b0;
            r_trig  <= 1'b0;
            r_cnt   <= 12'd0;
        end else begin
            r_ack0  <= w_ack0_nxt;
            r_ack1  <= w_ack1_nxt;
            r_data  <= w_data_nxt;
            r_sel   <= w_sel_nxt;
            r_val   <= w_val_nxt;
            r_long  <= w_long_nxt;
            r_lock  <= w_lock_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= w_busy_nxt;
            r_trig  <= w_trig_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.o_ack0      = r_ack0;
    assign bus.o_ack1      = r_ack1;
    assign bus.o_data      = r_data;
    assign bus.o_sel       = r_sel;
    assign bus.o_val       = r_val;
    assign bus.o_e_trigger = r_trig;
    assign bus.o_busy      = r_busy;
    assign bus.o_owner     = r_owner;
endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_lcd_bus_arbiter
// Brief   : Scoreboard bench for lcd_bus_arbiter (either arbitration build).
// Rev     : 1.0  initial release
// ============================================================================
module tb_lcd_bus_arbiter;
    localparam int WS = 35;
    localparam int WL = 1320;

    typedef struct packed {
        logic       data;
        logic [2:0] sel;
        logic [3:0] val;
        logic       lng;
        logic       lck;
    } cmd_t;

    typedef struct packed {
        logic       owner;
        logic       data;
        logic [2:0] sel;
        logic [3:0] val;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;
    logic ena_applied = 1'b0;
    logic wd1   = 1'b0;
    int   ena_period = 1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    cmd_t q0[$];
    cmd_t q1[$];
    exp_t sb[$];

    lcd_bus_arbiter_if bus ();

    lcd_bus_arbiter #(.WAIT_SHORT(WS), .WAIT_LONG(WL)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_ena     (ena),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_exp(input logic who, input cmd_t c);
        mk_exp = {who, c.data, c.sel, c.val};
    endfunction

    task automatic push_cmd(input logic who, input cmd_t c, input bit with_exp);
        if (who) q1.push_back(c); else q0.push_back(c);
        if (with_exp) sb.push_back(mk_exp(who, c));
    endtask

    // One cycle: score any ack, then present each requester's next command.
    task automatic step();
        exp_t e;
        exp_t act;
        cmd_t c;
        @(negedge clk);
        cyc++;
        ena_applied = ena;
        if (bus.o_ack0 || bus.o_ack1) begin
            n_cmp++;
            act = {bus.o_owner, bus.o_data, bus.o_sel, bus.o_val};
            if (bus.o_ack0 && bus.o_ack1) begin
                n_err++;
                $display("FAIL dual_ack: ack0=%0b ack1=%0b, required one-hot", bus.o_ack0, bus.o_ack1);
            end else if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: ack0=%0b ack1=%0b owner=%0b, required no ack", bus.o_ack0, bus.o_ack1, bus.o_owner);
            end else begin
                e = sb.pop_front();
                if (act !== e || bus.o_ack1 !== e.owner) begin
                    n_err++;
                    $display("FAIL grant: got ack1=%0b {owner,data,sel,val}=%h, required ack1=%0b %h", bus.o_ack1, act, e.owner, e);
                end
            end
            if (bus.o_ack0 && q0.size() > 0) void'(q0.pop_front());
            if (bus.o_ack1 && q1.size() > 0) void'(q1.pop_front());
        end
        if (q0.size() > 0) begin
            c = q0[0];
            bus.i_req0 = 1'b1; bus.i_data0 = c.data; bus.i_sel0 = c.sel;
            bus.i_val0 = c.val; bus.i_long0 = c.lng; bus.i_lock0 = c.lck;
        end else begin
            bus.i_req0 = 1'b0;
        end
        if (q1.size() > 0) begin
            c = q1[0];
            bus.i_req1 = 1'b1; bus.i_data1 = c.data; bus.i_sel1 = c.sel;
            bus.i_val1 = c.val; bus.i_long1 = c.lng; bus.i_lock1 = c.lck;
        end else if (wd1) begin
            bus.i_req1 = 1'b1; bus.i_data1 = 1'b1; bus.i_sel1 = 3'b111;
            bus.i_val1 = 4'hF; bus.i_long1 = 1'b0; bus.i_lock1 = 1'b0;
        end else begin
            bus.i_req1 = 1'b0;
        end
        ena = (ena_period <= 1) ? 1'b1 : ((cyc % ena_period) == 0);
    endtask

    task automatic drain(input int limit, input string tag);
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || bus.o_busy) && k < limit) begin
            step();
            k++;
        end
        n_cmp++;
        if (k >= limit) begin
            n_err++;
            $display("FAIL %s_timeout: pending=%0d busy=%0b after %0d cycles, required idle", tag, sb.size(), bus.o_busy, k);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); sb.delete();
        wd1 = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int k;
        logic [16:0] outs;
        rst_n = 1'b0;
        step(); step();
        outs = {bus.o_ack0, bus.o_ack1, bus.o_data, bus.o_sel, bus.o_val, bus.o_e_trigger, bus.o_busy, bus.o_owner};
        n_cmp++;
        if (outs !== 17'd0) begin n_err++; $display("FAIL reset_outputs: got %h, required 0", outs); end
        rst_n = 1'b1;
        ena_period = 8;
        push_cmd(1'b0, '{data:1'b1, sel:3'b101, val:4'hA, lng:1'b0, lck:1'b0}, 1'b1);
        k = 0;
        while (!bus.o_e_trigger && k < 20) begin step(); k++; end
        n_cmp++;
        if (bus.o_e_trigger !== 1'b1) begin n_err++; $display("FAIL reset_reach_issue: trigger=%0b, required 1", bus.o_e_trigger); end
        rst_n = 1'b0;
        q0.delete(); sb.delete();
        step();
        n_cmp++;
        if (bus.o_e_trigger !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_issue: trigger=%0b busy=%0b, required 0 0", bus.o_e_trigger, bus.o_busy);
        end
        outs = {bus.o_ack0, bus.o_ack1, bus.o_data, bus.o_sel, bus.o_val, bus.o_e_trigger, bus.o_busy, bus.o_owner};
        n_cmp++;
        if (outs !== 17'd0) begin n_err++; $display("FAIL reset_mid_outputs: got %h, required 0", outs); end
        step();
        rst_n = 1'b1;
        ena_period = 1;
        push_cmd(1'b1, '{data:1'b0, sel:3'b010, val:4'h3, lng:1'b0, lck:1'b0}, 1'b1);
        step();
        step();
        n_cmp++;
        if (bus.o_ack1 !== 1'b1) begin n_err++; $display("FAIL reset_then_ack1: ack1=%0b, required 1", bus.o_ack1); end
        drain(100, "reset");
    endtask

    task automatic test_single();
        int acks, trigs, busys;
        acks = 0; trigs = 0; busys = 0;
        ena_period = 1;
        push_cmd(1'b0, '{data:1'b1, sel:3'b000, val:4'h5, lng:1'b0, lck:1'b0}, 1'b1);
        for (int i = 0; i < 80; i++) begin
            step();
            acks  += int'(bus.o_ack0);
            trigs += int'(bus.o_e_trigger);
            busys += int'(bus.o_busy);
        end
        n_cmp++;
        if (acks != 1) begin n_err++; $display("FAIL single_ack_cycles: got %0d, required 1", acks); end
        n_cmp++;
        if (trigs != 1) begin n_err++; $display("FAIL single_trigger_cycles: got %0d, required 1", trigs); end
        // busy covers SETUP, ISSUE and the WS-cycle wait; the next grant follows one cycle later
        n_cmp++;
        if (busys != WS + 2) begin n_err++; $display("FAIL single_busy_cycles: got %0d, required %0d", busys, WS + 2); end
        n_cmp++;
        if (bus.o_val !== 4'h5 || bus.o_data !== 1'b1 || bus.o_owner !== 1'b0) begin
            n_err++; $display("FAIL single_latched: val=%h data=%0b owner=%0b, required 5 1 0", bus.o_val, bus.o_data, bus.o_owner);
        end
        drain(10, "single");
    endtask

    task automatic test_back_to_back();
        int t[$];
        ena_period = 1;
        for (int i = 0; i < 3; i++)
            push_cmd(1'b1, '{data:i[0], sel:3'(i), val:4'(i + 8), lng:1'b0, lck:1'b0}, 1'b1);
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.o_ack1) t.push_back(cyc);
        end
        n_cmp++;
        if (t.size() != 3) begin
            n_err++; $display("FAIL b2b_count: got %0d grants, required 3", t.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (t[i] - t[i-1] != WS + 3) begin
                    n_err++; $display("FAIL b2b_period: got %0d cycles, required %0d", t[i] - t[i-1], WS + 3);
                end
            end
        end
        drain(10, "b2b");
    endtask

    task automatic test_long();
        int k, ticks, early;
        logic pb, pt, seen;
        ena_period = 4;
        push_cmd(1'b1, '{data:1'b0, sel:3'b001, val:4'h1, lng:1'b1, lck:1'b0}, 1'b1);
        k = 0;
        while (!bus.o_ack1 && k < 20) begin step(); k++; end
        push_cmd(1'b0, '{data:1'b1, sel:3'b100, val:4'hC, lng:1'b0, lck:1'b0}, 1'b1);
        ticks = 0; early = 0; seen = 1'b0;
        pb = bus.o_busy; pt = bus.o_e_trigger;
        k = 0;
        while (!(seen && !bus.o_busy) && k < 6000) begin
            step();
            k++;
            if (ena_applied && pb && !pt && seen) ticks++;
            if (bus.o_ack0) early++;
            seen = seen | pt;
            pb = bus.o_busy; pt = bus.o_e_trigger;
        end
        n_cmp++;
        if (ticks != WL) begin n_err++; $display("FAIL long_wait_ticks: got %0d, required %0d", ticks, WL); end
        n_cmp++;
        if (early != 0) begin n_err++; $display("FAIL long_ack0_during_wait: got %0d, required 0", early); end
        ena_period = 1;
        drain(100, "long");
    endtask

    task automatic test_tie();
        cmd_t c0[4];
        cmd_t c1[4];
        int   r0, r1;
        logic last, w;
        do_reset();
        ena_period = 1;
        for (int i = 0; i < 4; i++) begin
            c0[i] = '{data:1'b0, sel:3'(i), val:4'(i), lng:1'b0, lck:1'b0};
            c1[i] = '{data:1'b1, sel:3'(7 - i), val:4'(i + 4), lng:1'b0, lck:1'b0};
            push_cmd(1'b0, c0[i], 1'b0);
            push_cmd(1'b1, c1[i], 1'b0);
        end
        r0 = 4; r1 = 4; last = 1'b1;
        while (r0 + r1 > 0) begin
            if (r0 > 0 && r1 > 0) begin
`ifdef LCD_ARB_RR_EN
                w = ~last;
`else
                w = 1'b0;
`endif
            end else begin
                w = (r1 > 0);
            end
            if (w) begin sb.push_back(mk_exp(1'b1, c1[4 - r1])); r1--; end
            else   begin sb.push_back(mk_exp(1'b0, c0[4 - r0])); r0--; end
            last = w;
        end
        drain(600, "tie");
    endtask

    task automatic test_lock();
        ena_period = 1;
        push_cmd(1'b0, '{data:1'b1, sel:3'b011, val:4'h1, lng:1'b0, lck:1'b1}, 1'b1);
        push_cmd(1'b0, '{data:1'b1, sel:3'b011, val:4'h2, lng:1'b0, lck:1'b1}, 1'b1);
        push_cmd(1'b0, '{data:1'b1, sel:3'b011, val:4'h3, lng:1'b0, lck:1'b0}, 1'b1);
        step(); step(); step();
        push_cmd(1'b1, '{data:1'b0, sel:3'b110, val:4'h9, lng:1'b0, lck:1'b0}, 1'b1);
        drain(300, "lock");
    endtask

    task automatic test_withdraw();
        int k, acks1, trigs;
        ena_period = 1;
        push_cmd(1'b0, '{data:1'b0, sel:3'b001, val:4'h7, lng:1'b0, lck:1'b0}, 1'b1);
        k = 0;
        while (!bus.o_ack0 && k < 10) begin step(); k++; end
        step(); step(); step();
        acks1 = 0; trigs = 0;
        wd1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            acks1 += int'(bus.o_ack1);
            trigs += int'(bus.o_e_trigger);
        end
        wd1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            acks1 += int'(bus.o_ack1);
            trigs += int'(bus.o_e_trigger);
        end
        n_cmp++;
        if (acks1 != 0) begin n_err++; $display("FAIL withdraw_ack1: got %0d, required 0", acks1); end
        n_cmp++;
        if (trigs != 0) begin n_err++; $display("FAIL withdraw_trigger: got %0d, required 0", trigs); end
        n_cmp++;
        if (bus.o_busy !== 1'b0 || bus.o_owner !== 1'b0) begin
            n_err++; $display("FAIL withdraw_idle: busy=%0b owner=%0b, required 0 0", bus.o_busy, bus.o_owner);
        end
        push_cmd(1'b1, '{data:1'b1, sel:3'b010, val:4'hE, lng:1'b0, lck:1'b0}, 1'b1);
        step();
        step();
        n_cmp++;
        if (bus.o_ack1 !== 1'b1) begin n_err++; $display("FAIL withdraw_then_grant: ack1=%0b, required 1", bus.o_ack1); end
        drain(100, "withdraw");
    endtask

    initial begin
        bus.i_req0 = 1'b0;  bus.i_req1 = 1'b0;
        bus.i_lock0 = 1'b0; bus.i_lock1 = 1'b0;
        bus.i_long0 = 1'b0; bus.i_long1 = 1'b0;
        bus.i_data0 = 1'b0; bus.i_data1 = 1'b0;
        bus.i_sel0 = 3'd0;  bus.i_sel1 = 3'd0;
        bus.i_val0 = 4'd0;  bus.i_val1 = 4'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_long();
        test_tie();
        test_lock();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
